// File: rtl/id_pkg.sv
// Shared types for the ID stage: opcode encoding, condition default and the
// registered decode bundle (ISA-width fields, widened at the stage outputs).
package id_pkg;

   typedef enum logic [3:0] {
      OpAdd, OpSub, OpRed, OpXor, OpSll, OpSra, OpRor, OpPaddsb,
      OpLw, OpSw, OpLlb, OpLhb, OpB, OpBr, OpPcs, OpHlt
   } op_e;

   localparam logic [2:0] COND_NONE = 3'h7;

   // Register fields stay 4 bits here; imm is the 16-bit extended value.
   typedef struct packed {
      op_e         opcode;
      logic [3:0]  rs1;
      logic [3:0]  rs2;
      logic [3:0]  rd;
      logic [15:0] imm;
      logic [2:0]  cond;
      logic        we;
      logic        mem_rd;
      logic        mem_wr;
      logic        branch;
   } dec_bundle_t;

   function automatic logic [15:0] sext4(input logic [3:0] v);
      return {{12{v[3]}}, v};
   endfunction

endpackage

// File: rtl/id_field_decode.sv
// Purely combinational field decode: instruction word to decode bundle plus
// flags telling which source registers the instruction actually reads.
module id_field_decode
   import id_pkg::*;
#(
   parameter int unsigned MEM_OFS_SHIFT  = 1,
   parameter int unsigned SHIFT_IMM_ZEXT = 1
) (
   input  logic [15:0] inst,
   output dec_bundle_t dec,
   output logic        use_rs1,
   output logic        use_rs2
);

   op_e         op;
   logic [15:0] mem_ofs;
   logic [15:0] shamt;

   assign op      = op_e'(inst[15:12]);
   assign mem_ofs = sext4(inst[3:0]) << MEM_OFS_SHIFT;
   assign shamt   = (SHIFT_IMM_ZEXT != 0) ? {12'h000, inst[3:0]} : sext4(inst[3:0]);

   always_comb begin
      dec        = '0;
      dec.opcode = op;
      dec.cond   = COND_NONE;
      use_rs1    = 1'b0;
      use_rs2    = 1'b0;
      unique case (op)
         OpAdd, OpSub, OpRed, OpXor, OpPaddsb: begin
            dec.rs1 = inst[7:4];
            dec.rs2 = inst[3:0];
            dec.rd  = inst[11:8];
            dec.we  = 1'b1;
            use_rs1 = 1'b1;
            use_rs2 = 1'b1;
         end
         OpSll, OpSra, OpRor: begin
            dec.rs1 = inst[7:4];
            dec.rd  = inst[11:8];
            dec.imm = shamt;
            dec.we  = 1'b1;
            use_rs1 = 1'b1;
         end
         OpLw: begin
            dec.rs1    = inst[7:4];
            dec.rd     = inst[11:8];
            dec.imm    = mem_ofs;
            dec.we     = 1'b1;
            dec.mem_rd = 1'b1;
            use_rs1    = 1'b1;
         end
         OpSw: begin
            dec.rs1    = inst[7:4];
            dec.rs2    = inst[11:8];
            dec.imm    = mem_ofs;
            dec.mem_wr = 1'b1;
            use_rs1    = 1'b1;
            use_rs2    = 1'b1;
         end
         // LLB/LHB merge into the old rd value, so rd is also read.
         OpLlb, OpLhb: begin
            dec.rs1 = inst[11:8];
            dec.rd  = inst[11:8];
            dec.imm = {{8{inst[7]}}, inst[7:0]};
            dec.we  = 1'b1;
            use_rs1 = 1'b1;
         end
         OpB: begin
            dec.imm    = {{7{inst[8]}}, inst[8:0]};
            dec.cond   = inst[11:9];
            dec.branch = 1'b1;
         end
         OpBr: begin
            dec.rs1    = inst[7:4];
            dec.cond   = inst[11:9];
            dec.branch = 1'b1;
            use_rs1    = 1'b1;
         end
         OpPcs: begin
            dec.rd = inst[11:8];
            dec.we = 1'b1;
         end
         OpHlt: begin
         end
         default: begin
         end
      endcase
   end

endmodule

// File: rtl/id_decode_stage.sv
// Registered decode stage between IF and EX with valid/ready on both sides,
// load-use bubble insertion, halt latching and branch flush.
module id_decode_stage
   import id_pkg::*;
#(
   parameter int unsigned DATA_W         = 16,
   parameter int unsigned REG_AW         = 4,
   parameter int unsigned MEM_OFS_SHIFT  = 1,
   parameter int unsigned SHIFT_IMM_ZEXT = 1,
   parameter int unsigned BUBBLE_CNT_W   = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   input  logic [15:0]             in_inst,
   output logic                    in_ready,
   input  logic                    flush,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [3:0]              out_opcode,
   output logic [REG_AW-1:0]       out_rs1,
   output logic [REG_AW-1:0]       out_rs2,
   output logic [REG_AW-1:0]       out_rd,
   output logic [DATA_W-1:0]       out_imm,
   output logic [2:0]              out_cond,
   output logic                    out_we,
   output logic                    out_mem_rd,
   output logic                    out_mem_wr,
   output logic                    out_branch,
   output logic                    halted,
   output logic [BUBBLE_CNT_W-1:0] bubble_cnt
);

   dec_bundle_t             dec;
   dec_bundle_t             bundle_q, bundle_d;
   logic                    use_rs1, use_rs2;
   logic                    hazard, accept;
   logic                    valid_q, valid_d;
   logic                    halted_q, halted_d;
   logic [BUBBLE_CNT_W-1:0] cnt_q, cnt_d;

   id_field_decode #(
      .MEM_OFS_SHIFT  (MEM_OFS_SHIFT),
      .SHIFT_IMM_ZEXT (SHIFT_IMM_ZEXT)
   ) u_field_decode (
      .inst    (in_inst),
      .dec     (dec),
      .use_rs1 (use_rs1),
      .use_rs2 (use_rs2)
   );

   // A load into r0 never stalls: r0 is not a real dependency.
   assign hazard = valid_q && bundle_q.mem_rd && (bundle_q.rd != 4'h0) &&
                   ((use_rs1 && (dec.rs1 == bundle_q.rd)) ||
                    (use_rs2 && (dec.rs2 == bundle_q.rd)));

   assign in_ready = !rst && !halted_q && !flush && !hazard && (!valid_q || out_ready);
   assign accept   = in_valid && in_ready;

   always_comb begin
      bundle_d = bundle_q;
      valid_d  = valid_q;
      halted_d = halted_q;
      cnt_d    = cnt_q;
      if (flush) begin
         valid_d  = 1'b0;
         halted_d = 1'b0;
      end else begin
         if (accept) begin
            bundle_d = dec;
            valid_d  = 1'b1;
            if (dec.opcode == OpHlt) begin
               halted_d = 1'b1;
            end
         end else if (out_ready) begin
            valid_d = 1'b0;
         end
         if (hazard && out_ready && (cnt_q != '1)) begin
            cnt_d = cnt_q + BUBBLE_CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bundle_q <= '0;
         valid_q  <= 1'b0;
         halted_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         bundle_q <= bundle_d;
         valid_q  <= valid_d;
         halted_q <= halted_d;
         cnt_q    <= cnt_d;
      end
   end

   assign out_valid  = valid_q;
   assign out_opcode = bundle_q.opcode;
   assign out_rs1    = REG_AW'(bundle_q.rs1);
   assign out_rs2    = REG_AW'(bundle_q.rs2);
   assign out_rd     = REG_AW'(bundle_q.rd);
   assign out_imm    = DATA_W'($signed(bundle_q.imm));
   assign out_cond   = bundle_q.cond;
   assign out_we     = bundle_q.we;
   assign out_mem_rd = bundle_q.mem_rd;
   assign out_mem_wr = bundle_q.mem_wr;
   assign out_branch = bundle_q.branch;
   assign halted     = halted_q;
   assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_id_decode_stage.sv
// Bench for id_decode_stage: directed scenarios then random traffic, all
// checked against an arithmetic reference model of the decode and handshake.
module tb_id_decode_stage;

   localparam int unsigned DATA_W         = 16;
   localparam int unsigned REG_AW         = 4;
   localparam int unsigned MEM_OFS_SHIFT  = 1;
   localparam int unsigned SHIFT_IMM_ZEXT = 1;
   localparam int unsigned BUBBLE_CNT_W   = 16;
   localparam int          CNT_MAX        = (1 << BUBBLE_CNT_W) - 1;

   logic                    clk = 1'b0;
   logic                    rst = 1'b0;
   logic                    in_valid = 1'b0;
   logic [15:0]             in_inst = 16'h0000;
   logic                    flush = 1'b0;
   logic                    out_ready = 1'b0;
   logic                    in_ready, out_valid, out_we, out_mem_rd, out_mem_wr, out_branch;
   logic                    halted;
   logic [3:0]              out_opcode;
   logic [REG_AW-1:0]       out_rs1, out_rs2, out_rd;
   logic [DATA_W-1:0]       out_imm;
   logic [2:0]              out_cond;
   logic [BUBBLE_CNT_W-1:0] bubble_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      int op, rs1, rs2, rd, imm, cond;
      bit we, mrd, mwr, br, u1, u2;
   } ref_t;

   bit   m_valid;
   bit   m_halt;
   int   m_cnt;
   ref_t m_b;

   always #5 clk = ~clk;

   id_decode_stage #(
      .DATA_W         (DATA_W),
      .REG_AW         (REG_AW),
      .MEM_OFS_SHIFT  (MEM_OFS_SHIFT),
      .SHIFT_IMM_ZEXT (SHIFT_IMM_ZEXT),
      .BUBBLE_CNT_W   (BUBBLE_CNT_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_inst    (in_inst),
      .in_ready   (in_ready),
      .flush      (flush),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_opcode (out_opcode),
      .out_rs1    (out_rs1),
      .out_rs2    (out_rs2),
      .out_rd     (out_rd),
      .out_imm    (out_imm),
      .out_cond   (out_cond),
      .out_we     (out_we),
      .out_mem_rd (out_mem_rd),
      .out_mem_wr (out_mem_wr),
      .out_branch (out_branch),
      .halted     (halted),
      .bubble_cnt (bubble_cnt)
   );

   // Reference decode from the ISA field table, using signed integer arithmetic.
   function automatic ref_t ref_dec(input logic [15:0] i);
      ref_t r;
      int op  = int'(i[15:12]);
      int a   = int'(i[11:8]);
      int b   = int'(i[7:4]);
      int c   = int'(i[3:0]);
      int c_s = (c >= 8) ? c - 16 : c;
      int v;
      r = '{default: 0};
      r.op   = op;
      r.cond = 7;
      if (op <= 3 || op == 7) begin
         r.rd = a; r.rs1 = b; r.rs2 = c; r.we = 1; r.u1 = 1; r.u2 = 1;
      end else if (op <= 6) begin
         r.rd = a; r.rs1 = b; r.imm = (SHIFT_IMM_ZEXT != 0) ? c : c_s; r.we = 1; r.u1 = 1;
      end else if (op == 8) begin
         r.rd = a; r.rs1 = b; r.imm = c_s * (1 << MEM_OFS_SHIFT); r.we = 1; r.mrd = 1; r.u1 = 1;
      end else if (op == 9) begin
         r.rs2 = a; r.rs1 = b; r.imm = c_s * (1 << MEM_OFS_SHIFT); r.mwr = 1; r.u1 = 1; r.u2 = 1;
      end else if (op == 10 || op == 11) begin
         v = int'(i[7:0]);
         r.rd = a; r.rs1 = a; r.imm = (v >= 128) ? v - 256 : v; r.we = 1; r.u1 = 1;
      end else if (op == 12) begin
         v = int'(i[8:0]);
         r.imm = (v >= 256) ? v - 512 : v; r.cond = int'(i[11:9]); r.br = 1;
      end else if (op == 13) begin
         r.rs1 = b; r.cond = int'(i[11:9]); r.br = 1; r.u1 = 1;
      end else if (op == 14) begin
         r.rd = a; r.we = 1;
      end
      return r;
   endfunction

   function automatic logic [63:0] exp_vec(input ref_t r);
      return 64'({4'(r.op), 4'(r.rs1), 4'(r.rs2), 4'(r.rd), 16'(r.imm), 3'(r.cond),
                  r.we, r.mrd, r.mwr, r.br});
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_state(input string tag);
      chk({tag, "/out_valid"}, 64'(out_valid), 64'(m_valid));
      chk({tag, "/halted"}, 64'(halted), 64'(m_halt));
      chk({tag, "/bubble_cnt"}, 64'(bubble_cnt), 64'(m_cnt));
      chk({tag, "/bundle"},
          64'({out_opcode, out_rs1, out_rs2, out_rd, out_imm, out_cond,
               out_we, out_mem_rd, out_mem_wr, out_branch}),
          exp_vec(m_b));
   endtask

   // Asynchronous reset asserted and checked between clock edges.
   task automatic do_reset();
      in_valid = 1'b0;
      flush    = 1'b0;
      rst      = 1'b1;
      #2;
      m_valid = 1'b0;
      m_halt  = 1'b0;
      m_cnt   = 0;
      m_b     = '{default: 0};
      chk("reset/in_ready", 64'(in_ready), 64'(0));
      check_state("reset");
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   // One clock: check in_ready against the model, clock, advance model, check state.
   task automatic cycle(input string tag);
      ref_t d;
      bit   hz, rdy;
      #2;
      d   = ref_dec(in_inst);
      hz  = m_valid && m_b.mrd && (m_b.rd != 0) &&
            ((d.u1 && d.rs1 == m_b.rd) || (d.u2 && d.rs2 == m_b.rd));
      rdy = !m_halt && !flush && !hz && (!m_valid || out_ready);
      chk({tag, "/in_ready"}, 64'(in_ready), 64'(rdy));
      @(posedge clk);
      #1;
      if (flush) begin
         m_valid = 1'b0;
         m_halt  = 1'b0;
      end else begin
         if (in_valid && rdy) begin
            m_b     = d;
            m_valid = 1'b1;
            if (d.op == 15) m_halt = 1'b1;
         end else if (out_ready) begin
            m_valid = 1'b0;
         end
         if (hz && out_ready && m_cnt < CNT_MAX) m_cnt++;
      end
      check_state(tag);
   endtask

   function automatic logic [15:0] rand_inst();
      logic [15:0] v;
      int unsigned op;
      v  = 16'($urandom);
      op = $urandom_range(0, 15);
      if (op == 15 && $urandom_range(0, 3) != 0) op = 8;
      v[15:12] = 4'(op);
      if ($urandom_range(0, 1) == 1) begin
         v[11:10] = 2'b00;
         v[7:6]   = 2'b00;
         v[3:2]   = 2'b00;
      end
      return v;
   endfunction

   initial begin
      #1;
      do_reset();

      // ADD r1 = r2 + r3
      out_ready = 1'b1; in_valid = 1'b1; in_inst = 16'h0123;
      cycle("t1");
      chk("t1/valid", 64'(out_valid), 64'(1));
      chk("t1/rd", 64'(out_rd), 64'(1));
      chk("t1/rs1", 64'(out_rs1), 64'(2));
      chk("t1/rs2", 64'(out_rs2), 64'(3));
      chk("t1/we", 64'(out_we), 64'(1));
      chk("t1/imm", 64'(out_imm), 64'(0));
      chk("t1/cond", 64'(out_cond), 64'(7));

      // LW r1 then ADD reading r1: one bubble
      do_reset();
      out_ready = 1'b1; in_valid = 1'b1; in_inst = 16'h8127;
      cycle("t2_lw");
      chk("t2/lw_imm", 64'(out_imm), 64'(16'h000E));
      in_inst = 16'h0312;
      cycle("t2_bubble");
      chk("t2/bubble_valid", 64'(out_valid), 64'(0));
      chk("t2/bubble_cnt", 64'(bubble_cnt), 64'(1));
      cycle("t2_add");
      chk("t2/add_valid", 64'(out_valid), 64'(1));
      chk("t2/add_rs2", 64'(out_rs2), 64'(2));
      chk("t2/add_rd", 64'(out_rd), 64'(3));

      // LW into r0: no bubble
      do_reset();
      out_ready = 1'b1; in_valid = 1'b1; in_inst = 16'h8027;
      cycle("t3_lw");
      in_inst = 16'h0302;
      cycle("t3_add");
      chk("t3/valid", 64'(out_valid), 64'(1));
      chk("t3/opcode", 64'(out_opcode), 64'(0));
      chk("t3/bubble_cnt", 64'(bubble_cnt), 64'(0));

      // SW with negative word offset
      do_reset();
      out_ready = 1'b1; in_valid = 1'b1; in_inst = 16'h93AF;
      cycle("t4");
      chk("t4/imm", 64'(out_imm), 64'(16'hFFFE));
      chk("t4/rs2", 64'(out_rs2), 64'(3));
      chk("t4/rs1", 64'(out_rs1), 64'(10));
      chk("t4/mem_wr", 64'(out_mem_wr), 64'(1));
      chk("t4/we", 64'(out_we), 64'(0));

      // Back-pressure for three cycles, then release
      do_reset();
      out_ready = 1'b1; in_valid = 1'b1; in_inst = 16'h0123;
      cycle("t5_load");
      out_ready = 1'b0; in_inst = 16'h4567;
      for (int k = 0; k < 3; k++) begin
         cycle("t5_stall");
         chk("t5/stall_rd", 64'(out_rd), 64'(1));
         chk("t5/stall_valid", 64'(out_valid), 64'(1));
         chk("t5/stall_in_ready", 64'(in_ready), 64'(0));
      end
      out_ready = 1'b1;
      cycle("t5_release");
      chk("t5/new_opcode", 64'(out_opcode), 64'(4));
      chk("t5/new_rd", 64'(out_rd), 64'(5));
      chk("t5/new_imm", 64'(out_imm), 64'(7));

      // HLT, blocked ADD, flush, then ADD accepted
      do_reset();
      out_ready = 1'b1; in_valid = 1'b1; in_inst = 16'hF000;
      cycle("t6_hlt");
      chk("t6/halted", 64'(halted), 64'(1));
      in_inst = 16'h0123;
      cycle("t6_blocked");
      chk("t6/blocked_in_ready", 64'(in_ready), 64'(0));
      chk("t6/blocked_halted", 64'(halted), 64'(1));
      flush = 1'b1;
      cycle("t6_flush");
      chk("t6/flush_halted", 64'(halted), 64'(0));
      chk("t6/flush_valid", 64'(out_valid), 64'(0));
      flush = 1'b0;
      cycle("t6_resume");
      chk("t6/resume_valid", 64'(out_valid), 64'(1));
      chk("t6/resume_rs2", 64'(out_rs2), 64'(3));

      // Random traffic with occasional flush and mid-run reset
      do_reset();
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 199) == 0) do_reset();
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 19) == 0);
         in_inst   = rand_inst();
         cycle("rnd");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/id_decode_stage.md
Name: id_decode_stage

Overview:
- Registered, parametrised instruction-decode stage for the 16-bit core. It sits between fetch (IF) and execute (EX).
- Decodes one instruction per cycle into register addresses, an immediate, a condition code and control flags, and holds them in a pipeline register with valid/ready handshakes on both sides.
- Adds three things plain combinational decode does not have: load-use bubble insertion, halt latching and branch flush.

Parameters:
- DATA_W, 16, instruction/immediate width (≥16).
- REG_AW, 4, register address width; ISA fields stay 4 bits, zero-extended to REG_AW.
- MEM_OFS_SHIFT, 1, left-shift applied to LW/SW offset (0 = byte, 1 = word).
- SHIFT_IMM_ZEXT, 1, 1 = zero-extend SLL/SRA/ROR amount, 0 = sign-extend.
- BUBBLE_CNT_W, 16, width of the saturating bubble counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  IF holds an instruction
- in_inst  in  16  instruction word
- in_ready  out  1  stage accepts in_inst this cycle
- flush  in  1  taken-branch kill from EX
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  EX accepts the bundle
- out_opcode  out  4  inst[15:12]
- out_rs1, out_rs2, out_rd  out  REG_AW  read/read/write addresses
- out_imm  out  DATA_W  extended immediate
- out_cond  out  3  inst[11:9] for B/BR, else 3'h7
- out_we, out_mem_rd, out_mem_wr, out_branch  out  1  control flags
- halted  out  1  HLT has been issued
- bubble_cnt  out  BUBBLE_CNT_W  load-use bubbles inserted

Behaviour:
- Reset (async, rst=1): every out_* = 0, out_valid = 0, halted = 0, bubble_cnt = 0. in_ready = 0 while rst is high.

Field mapping (per opcode):
- 0–3 and 7: rs1=[7:4], rs2=[3:0], rd=[11:8], we=1.
- 4–6: rs1=[7:4], rd=[11:8], imm=[3:0] extended per SHIFT_IMM_ZEXT, we=1.
- 8 LW: rs1=[7:4], rd=[11:8], imm=sext([3:0])<<MEM_OFS_SHIFT, we=1, mem_rd=1.
- 9 SW: rs1=[7:4], rs2=[11:8], same imm as LW, mem_wr=1.
- A/B (LLB/LHB): rs1=rd=[11:8], imm=sext([7:0]), we=1.
- C (B): imm=sext([8:0]), cond=[11:9], branch=1.
- D (BR): rs1=[7:4], cond=[11:9], branch=1.
- E (PCS): rd=[11:8], we=1.
- F (HLT): no register or flag use.
- Every unused field is 0.

Handshake:
- in_ready = !rst && !halted && !flush && !hazard && (!out_valid || out_ready).
- A transfer in occurs when in_valid && in_ready. The bundle is registered, so latency is 1 cycle.
- While out_valid && !out_ready, all out_* hold stable.
- When out_ready is high and no new instruction is loaded, out_valid falls to 0.

Load-use hazard:
- hazard = out_valid && out_mem_rd && out_rd≠0 && (out_rd == a source used by in_inst).
- Sources used by in_inst: rs1 for all ops except C/E/F; rs2 for 0–3, 7 and 9.
- When out_ready is high under hazard: out_valid → 0 (one bubble) and bubble_cnt increments, saturating at all-ones.
- The next cycle has no hazard, so the instruction is accepted. Exactly one bubble per load-use pair.

Halt:
- Accepting HLT sets halted = 1 at the same edge the HLT is registered.
- While halted, in_ready = 0 and out_valid drains normally.

Flush:
- Highest priority. On the edge, out_valid → 0 and halted → 0; in_inst is dropped; bubble_cnt is unchanged.
- flush together with in_valid: the instruction is not accepted.

Reset mid-operation: immediate clear of all state. A pending hazard or halt is lost.

Decomposition:
- Package id_pkg holds:
  - opcode enum op_e with 16 values: ADD, SUB, RED, XOR, SLL, SRA, ROR, PADDSB, LW, SW, LLB, LHB, B, BR, PCS, HLT.
  - COND_NONE = 3'h7.
  - Struct dec_bundle_t for the registered fields.
- Sub-module id_field_decode is purely combinational (inst → dec_bundle_t plus source-use flags) and is instantiated once. The stage module holds the register, handshake, hazard, halt and counter logic.

Test Plan:
1. ADD 0x0123 with out_ready=1 → next cycle out_valid=1, rd=1, rs1=2, rs2=3, we=1, imm=0, cond=7.
2. LW 0x8127 then ADD 0x0312 back-to-back → one cycle with out_valid=0 between them, bubble_cnt=1; ADD issues with rs2=2.
3. LW 0x8027 (rd=0) then ADD 0x0302 → no bubble, bubble_cnt=0.
4. SW 0x93AF with MEM_OFS_SHIFT=1 → imm=16'hFFFE, rs2=3, mem_wr=1, we=0.
5. out_ready held 0 for 3 cycles with in_valid=1 → outputs stable, in_ready=0; on release, the next instruction loads in 1 cycle.
6. HLT 0xF000 then ADD → halted=1, in_ready=0; assert flush → halted=0, out_valid=0, ADD accepted the cycle after.
